// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader
// Consumer-side adapter for the synchronous FIFO. Pops words through the
// FIFO read port and presents them on a valid/ready stream. A 2-entry skid
// buffer absorbs the one-cycle FIFO read latency so the stream never drops
// a word and never bubbles under continuous m_ready. A flush sequence
// drains and discards the FIFO contents.
//
// Build option: define FIFO_READER_COUNT_EN to build the 16-bit wrapping
// delivered-word counter on rd_count; otherwise rd_count is tied to zero.
module fifo_stream_reader #(
  parameter int FIFO_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  rd_en,
  input  logic [FIFO_WIDTH-1:0] data_out,
  input  logic                  empty,
  input  logic                  underflow,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [FIFO_WIDTH-1:0] m_data,
  input  logic                  flush,
  output logic                  busy,
  output logic                  err,
  output logic [15:0]           rd_count
);

  typedef enum logic {
    ST_STREAM = 1'b0,
    ST_FLUSH  = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [1:0]            occ_q, occ_d;
  logic                  inflight_q;
  logic [FIFO_WIDTH-1:0] buf0_q, buf0_d;
  logic [FIFO_WIDTH-1:0] buf1_q, buf1_d;
  logic                  err_q;
  logic                  pop;
  logic                  wr;
  logic [2:0]            level;

  // buf0 is the head of the skid buffer; it is never written in FLUSH,
  // so occ stays 0 and m_valid stays low there.
  assign m_valid = (occ_q != 2'd0);
  assign m_data  = buf0_q;
  assign pop     = m_valid && m_ready;
  assign busy    = (state_q == ST_FLUSH);
  assign err     = err_q;

  // Words committed to the buffer once this cycle's pop leaves.
  assign level = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};

  // Next state, FIFO pop request and buffer-write qualifier.
  always_comb begin
    state_d = state_q;
    rd_en   = 1'b0;
    wr      = 1'b0;
    case (state_q)
      ST_STREAM: begin
        rd_en = !empty && (level < 3'd2);
        wr    = inflight_q && !underflow;
        if (flush) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        rd_en = !empty;
        if (empty && !inflight_q) state_d = ST_STREAM;
      end
      default: state_d = ST_STREAM;
    endcase
    if (rst) rd_en = 1'b0;
  end

  // Skid buffer: pop shifts buf1 into the head, the returning word lands at
  // the first free slot after the pop. A flush request empties it outright.
  always_comb begin
    occ_d  = occ_q;
    buf0_d = buf0_q;
    buf1_d = buf1_q;
    if (state_q == ST_STREAM && flush) begin
      occ_d = 2'd0;
    end else begin
      occ_d = occ_q + {1'b0, wr} - {1'b0, pop};
      if (pop) buf0_d = buf1_q;
      if (wr) begin
        if ((occ_q - {1'b0, pop}) == 2'd0) buf0_d = data_out;
        else                               buf1_d = data_out;
      end
    end
  end

  // State, buffer and sticky error registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_STREAM;
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      buf0_q     <= '0;
      buf1_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      occ_q      <= occ_d;
      inflight_q <= rd_en;
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
      if (inflight_q && underflow) err_q <= 1'b1;
    end
  end

`ifdef FIFO_READER_COUNT_EN
  logic [15:0] cnt_q, cnt_d;

  assign cnt_d    = cnt_q + 16'd1;
  assign rd_count = cnt_q;

  // Delivered-word counter, wraps naturally at 0xFFFF.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      cnt_q <= 16'd0;
    else if (pop) cnt_q <= cnt_d;
  end
`else
  assign rd_count = 16'd0;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Testbench for fifo_stream_reader: a behavioural FIFO drives the read port,
// a scoreboard holds the words taken from the FIFO in order and checks every
// stream handshake against it.
`timescale 1ns/1ps
module tb_fifo_stream_reader;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         rd_en;
  logic [W-1:0] data_out = '0;
  logic         empty = 1'b1;
  logic         underflow = 1'b0;
  logic         m_valid;
  logic         m_ready;
  logic [W-1:0] m_data;
  logic         flush;
  logic         busy;
  logic         err;
  logic [15:0]  rd_count;

  always #5 clk = ~clk;

  fifo_stream_reader #(.FIFO_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .data_out(data_out),
    .empty(empty), .underflow(underflow), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .flush(flush), .busy(busy),
    .err(err), .rd_count(rd_count)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] cnt_model(input int n);
`ifdef FIFO_READER_COUNT_EN
    return n[15:0];
`else
    return 16'd0;
`endif
  endfunction

  // Behavioural FIFO with a write port driven by the stimulus.
  logic [W-1:0] fq[$];
  logic         f_wr = 1'b0;
  logic [W-1:0] f_wdata = '0;
  int           force_req = 0;
  int           force_done = 0;
  int           rd_pulses = 0;
  logic         und_n;

  always @(posedge clk) begin
    und_n = 1'b0;
    if (rd_en) begin
      rd_pulses++;
      if (force_req != force_done) begin
        und_n = 1'b1;
        force_done++;
      end else if (fq.size() > 0) begin
        data_out <= fq.pop_front();
      end else begin
        und_n = 1'b1;
      end
    end
    if (f_wr) fq.push_back(f_wdata);
    underflow <= und_n;
    empty     <= (fq.size() == 0);
  end

  // Reference: words leave the FIFO in order and must appear on the stream
  // in that order; flush and reset discard everything not yet delivered.
  logic [W-1:0] sb[$];
  logic [W-1:0] exp_word;
  int           exp_cnt = 0;
  logic         exp_err = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      exp_cnt = 0;
      exp_err = 1'b0;
    end else begin
      if (underflow) exp_err = 1'b1;
      if (m_valid && m_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_handshake", {31'd0, m_valid}, 32'd0);
        end else begin
          exp_word = sb.pop_front();
          chk("stream_data", {16'd0, m_data}, {16'd0, exp_word});
        end
        exp_cnt = (exp_cnt + 1) & 32'hFFFF;
      end
      if (flush && !busy) sb.delete();
      else if (!busy && rd_en && (force_req == force_done) && fq.size() > 0)
        sb.push_back(fq[0]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic wait_valid(input int limit);
    for (int i = 0; i < limit && !m_valid; i++) tick();
  endtask

  logic [W-1:0] w[8];
  int           p0;
  int           base;

  initial begin
    rst = 1'b1; m_ready = 1'b0; flush = 1'b0;
    idle(3);
    chk("rst_rd_en", {31'd0, rd_en}, 32'd0);
    chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_m_data", {16'd0, m_data}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_rd_count", {16'd0, rd_count}, 32'd0);
    rst = 1'b0;
    idle(2);

    // Three words streaming; first m_valid two cycles after empty falls.
    m_ready = 1'b1;
    f_wr = 1'b1; f_wdata = 16'h1111; tick();
    chk("t1_lat_c0", {31'd0, m_valid}, 32'd0);
    f_wdata = 16'h2222; tick();
    chk("t1_lat_c1", {31'd0, m_valid}, 32'd0);
    f_wdata = 16'h3333; tick();
    f_wr = 1'b0;
    chk("t1_valid0", {31'd0, m_valid}, 32'd1);
    chk("t1_data0", {16'd0, m_data}, 32'h1111);
    tick();
    chk("t1_data1", {16'd0, m_data}, 32'h2222);
    tick();
    chk("t1_data2", {16'd0, m_data}, 32'h3333);
    tick();
    chk("t1_valid_end", {31'd0, m_valid}, 32'd0);
    chk("t1_rd_count", {16'd0, rd_count}, {16'd0, cnt_model(3)});

    // Backpressure: eight words, m_ready low, only two pops.
    m_ready = 1'b0;
    p0 = rd_pulses;
    for (int i = 0; i < 8; i++) begin
      w[i] = W'($urandom);
      f_wr = 1'b1; f_wdata = w[i]; tick();
    end
    f_wr = 1'b0;
    idle(10);
    chk("t2_rd_pulses", rd_pulses - p0, 32'd2);
    chk("t2_hold_valid", {31'd0, m_valid}, 32'd1);
    chk("t2_hold_data", {16'd0, m_data}, {16'd0, w[0]});
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("t2_gapless_valid", {31'd0, m_valid}, 32'd1);
      chk("t2_order", {16'd0, m_data}, {16'd0, w[i]});
      tick();
    end
    chk("t2_valid_end", {31'd0, m_valid}, 32'd0);
    chk("t2_rd_count", {16'd0, rd_count}, {16'd0, cnt_model(11)});

    // m_ready toggling every cycle.
    m_ready = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      f_wr = 1'b1; f_wdata = W'(i); tick();
    end
    f_wr = 1'b0;
    idle(3);
    base = exp_cnt;
    for (int i = 0; i < 40 && (exp_cnt - base) < 8; i++) begin
      m_ready = (i % 2 == 0);
      tick();
    end
    m_ready = 1'b0;
    idle(2);
    chk("t3_delivered", exp_cnt - base, 32'd8);
    chk("t3_sb_empty", sb.size(), 32'd0);
    chk("t3_rd_count", {16'd0, rd_count}, {16'd0, cnt_model(19)});

    // Flush with two buffered words and five still in the FIFO.
    for (int i = 0; i < 7; i++) begin
      f_wr = 1'b1; f_wdata = W'(16'h4000 + i); tick();
    end
    f_wr = 1'b0;
    idle(4);
    chk("t4_pre_valid", {31'd0, m_valid}, 32'd1);
    flush = 1'b1; tick(); flush = 1'b0;
    chk("t4_valid_drop", {31'd0, m_valid}, 32'd0);
    chk("t4_busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 40 && busy; i++) begin
      if (m_valid) chk("t4_valid_in_flush", {31'd0, m_valid}, 32'd0);
      tick();
    end
    chk("t4_busy_fall", {31'd0, busy}, 32'd0);
    chk("t4_fifo_drained", {31'd0, empty}, 32'd1);
    m_ready = 1'b1;
    f_wr = 1'b1; f_wdata = 16'hABCD; tick(); f_wr = 1'b0;
    wait_valid(10);
    chk("t4_first_valid", {31'd0, m_valid}, 32'd1);
    chk("t4_first_data", {16'd0, m_data}, 32'hABCD);
    tick();
    chk("t4_no_extra", {31'd0, m_valid}, 32'd0);
    chk("t4_rd_count", {16'd0, rd_count}, {16'd0, cnt_model(20)});

    // Underflow on the read after an rd_en.
    force_req++;
    f_wr = 1'b1; f_wdata = 16'h5A5A; tick(); f_wr = 1'b0;
    wait_valid(10);
    chk("t5_valid", {31'd0, m_valid}, 32'd1);
    chk("t5_data", {16'd0, m_data}, 32'h5A5A);
    chk("t5_err_set", {31'd0, err}, 32'd1);
    tick();
    chk("t5_no_dup", {31'd0, m_valid}, 32'd0);
    idle(5);
    chk("t5_err_sticky", {31'd0, err}, {31'd0, exp_err});
    chk("t5_rd_count", {16'd0, rd_count}, {16'd0, cnt_model(21)});

    // Reset with a full skid buffer; remaining FIFO words survive.
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      f_wr = 1'b1; f_wdata = W'(16'h6000 + i); tick();
    end
    f_wr = 1'b0;
    idle(4);
    rst = 1'b1;
    #1;
    chk("t6_valid", {31'd0, m_valid}, 32'd0);
    chk("t6_rd_en", {31'd0, rd_en}, 32'd0);
    chk("t6_err", {31'd0, err}, 32'd0);
    chk("t6_rd_count", {16'd0, rd_count}, 32'd0);
    chk("t6_busy", {31'd0, busy}, 32'd0);
    idle(2);
    rst = 1'b0;
    m_ready = 1'b1;
    wait_valid(10);
    chk("t6_next_data", {16'd0, m_data}, 32'h6002);
    tick();
    chk("t6_next_data2", {16'd0, m_data}, 32'h6003);
    tick();
    chk("t6_drained", {31'd0, m_valid}, 32'd0);
    chk("t6_count_after", {16'd0, rd_count}, {16'd0, cnt_model(2)});

    // Reset while a word is in flight from the FIFO: it is lost.
    f_wr = 1'b1; f_wdata = 16'h7777; tick(); f_wr = 1'b0;
    tick();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(4);
    chk("t7_inflight_dropped", {31'd0, m_valid}, 32'd0);
    f_wr = 1'b1; f_wdata = 16'h7778; tick(); f_wr = 1'b0;
    wait_valid(10);
    chk("t7_new_word", {16'd0, m_data}, 32'h7778);
    tick();
    chk("t7_rd_count", {16'd0, rd_count}, {16'd0, cnt_model(1)});

    // Random traffic with occasional flushes, checked by the scoreboard.
    for (int i = 0; i < 400; i++) begin
      m_ready = 1'($urandom_range(0, 1));
      f_wr    = (($urandom % 3) != 0);
      f_wdata = W'($urandom);
      flush   = (($urandom % 60) == 0);
      tick();
    end
    f_wr = 1'b0; flush = 1'b0; m_ready = 1'b1;
    for (int i = 0; i < 400 && (m_valid || !empty || busy || sb.size() != 0); i++) tick();
    idle(3);
    chk("rnd_sb_empty", sb.size(), 32'd0);
    chk("rnd_valid_end", {31'd0, m_valid}, 32'd0);
    chk("rnd_rd_count", {16'd0, rd_count}, {16'd0, cnt_model(exp_cnt)});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
